// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send and clocks one command byte out to the device.
// Optional watchdog abort on a silent device is built when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] din,
   input  logic       ps2_c,
   input  logic       ps2_d,
   output logic       ps2_c_oe,
   output logic       ps2_d_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout
);

   localparam int CW = $clog2(INHIBIT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [9:0]    shift_reg, shift_next;
   logic [3:0]    bitcnt_reg, bitcnt_next;
   logic          c_oe_reg, c_oe_next;
   logic          d_oe_reg, d_oe_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;
   logic          ack_err_reg, ack_err_next;
   logic          flag_reg, flag_next;
   logic          c_meta_reg, c_sync_reg, c_prev_reg;
   logic          d_meta_reg, d_sync_reg;
   logic          fall;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wd_reg, wd_next;
   logic          timeout_reg, timeout_next;
`endif

   assign fall = c_prev_reg & ~c_sync_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // Idle bus level is high, so the synchronisers start there to avoid a false fall.
         c_meta_reg  <= 1'b1;
         c_sync_reg  <= 1'b1;
         c_prev_reg  <= 1'b1;
         d_meta_reg  <= 1'b1;
         d_sync_reg  <= 1'b1;
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         shift_reg   <= '0;
         bitcnt_reg  <= '0;
         c_oe_reg    <= 1'b0;
         d_oe_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         ack_err_reg <= 1'b0;
         flag_reg    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         wd_reg      <= '0;
         timeout_reg <= 1'b0;
`endif
      end else begin
         c_meta_reg  <= ps2_c;
         c_sync_reg  <= c_meta_reg;
         c_prev_reg  <= c_sync_reg;
         d_meta_reg  <= ps2_d;
         d_sync_reg  <= d_meta_reg;
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         shift_reg   <= shift_next;
         bitcnt_reg  <= bitcnt_next;
         c_oe_reg    <= c_oe_next;
         d_oe_reg    <= d_oe_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         ack_err_reg <= ack_err_next;
         flag_reg    <= flag_next;
`ifdef PS2_TX_TIMEOUT_EN
         wd_reg      <= wd_next;
         timeout_reg <= timeout_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      shift_next   = shift_reg;
      bitcnt_next  = bitcnt_reg;
      d_oe_next    = d_oe_reg;
      busy_next    = busy_reg;
      flag_next    = flag_reg;
      done_next    = 1'b0;
      ack_err_next = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_next      = wd_reg;
      timeout_next = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = INHIBIT;
               shift_next = {1'b1, ~^din, din};
               cnt_next   = '0;
               busy_next  = 1'b1;
               flag_next  = 1'b0;
               d_oe_next  = 1'b0;
            end
         end
         INHIBIT: begin
            if (cnt_reg == CW'(INHIBIT_CYCLES - 1)) begin
               state_next = REQ;
               d_oe_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         REQ: begin
            state_next  = SEND;
            bitcnt_next = '0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_next     = '0;
`endif
         end
         SEND: begin
            // The stop bit in shift[0] at the tenth fall releases the data line.
            if (fall) begin
               d_oe_next   = ~shift_reg[0];
               shift_next  = {1'b0, shift_reg[9:1]};
               bitcnt_next = bitcnt_reg + 4'd1;
               if (bitcnt_reg == 4'd9) state_next = ACK;
            end
         end
         ACK: begin
            if (fall) begin
               flag_next  = d_sync_reg;
               state_next = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (c_sync_reg && d_sync_reg) begin
               state_next   = IDLE;
               done_next    = 1'b1;
               ack_err_next = flag_reg;
               busy_next    = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      if (state_reg == SEND || state_reg == ACK) begin
         if (fall) begin
            wd_next = '0;
         end else if (wd_reg == WW'(TIMEOUT_CYCLES - 1)) begin
            state_next   = IDLE;
            d_oe_next    = 1'b0;
            done_next    = 1'b1;
            timeout_next = 1'b1;
            busy_next    = 1'b0;
            flag_next    = 1'b0;
         end else begin
            wd_next = wd_reg + WW'(1);
         end
      end
`endif
      c_oe_next = (state_next == INHIBIT) || (state_next == REQ);
   end

   assign ps2_c_oe = c_oe_reg;
   assign ps2_d_oe = d_oe_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign ack_err  = ack_err_reg;
`ifdef PS2_TX_TIMEOUT_EN
   assign timeout  = timeout_reg;
`else
   // Constant 0; the expression keeps TIMEOUT_CYCLES referenced so both builds share one parameter list.
   assign timeout  = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain bus model, device clock model and a done-driven scoreboard.
module tb_ps2_host_tx;

   localparam int INH = 40;
   localparam int TO  = 300;
   localparam int H   = 25;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] din;
   logic       ps2_c, ps2_d;
   logic       ps2_c_oe, ps2_d_oe, busy, done, ack_err, timeout;
   logic       dev_c_low = 1'b0;
   logic       dev_d_low = 1'b0;

   assign ps2_c = ~(ps2_c_oe | dev_c_low);
   assign ps2_d = ~(ps2_d_oe | dev_d_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .din(din),
      .ps2_c(ps2_c), .ps2_d(ps2_d),
      .ps2_c_oe(ps2_c_oe), .ps2_d_oe(ps2_d_oe),
      .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] din;
      logic       par;
      logic       ack_low;
      logic       exp_ack_err;
      bit         poke;
   } vec_t;

   typedef struct {
      logic [10:0] frame;
      logic        ack_err;
      logic        tmo;
      bit          chk_frame;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   vec_t        vecs[6];
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   int          cyc = 0;
   int          done_cyc = 0;
   logic [10:0] cap_frame = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse pops the oldest expected transfer.
   always @(negedge clk) begin
      if (reset && done) begin
         done_cnt++;
         done_cyc = cyc;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done act=1 exp=0");
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.chk_frame) check("frame", 32'(cap_frame), 32'(mon_e.frame));
            check("ack_err", 32'(ack_err), 32'(mon_e.ack_err));
            check("timeout", 32'(timeout), 32'(mon_e.tmo));
            check("busy_at_done", 32'(busy), 32'd0);
            $display("xfer frame=%03h ack_err=%b timeout=%b", cap_frame, ack_err, timeout);
         end
      end
   end

   task automatic dev_clock(input int nfalls, input logic ack_low, input bit poke);
      for (int k = 0; k < nfalls; k++) begin
         repeat (H) @(negedge clk);
         cap_frame[k] = ps2_d;
         if (k == 10) begin
            check("released_before_ack", 32'(ps2_d_oe), 32'd0);
            if (ack_low) dev_d_low = 1'b1;
            repeat (4) @(negedge clk);
         end
         if (poke && k == 4) begin
            start = 1'b1;
            din   = 8'h00;
            @(negedge clk);
            start = 1'b0;
         end
         dev_c_low = 1'b1;
         repeat (H) @(negedge clk);
         dev_c_low = 1'b0;
      end
   endtask

   task automatic begin_xfer(input logic [7:0] d, input bit poke, output int n);
      @(negedge clk);
      din   = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      din   = 8'($urandom);
      check("busy_after_start", 32'(busy), 32'd1);
      n = 0;
      while (ps2_c_oe === 1'b1 && n < INH + 50) begin
         n++;
         if (poke && n == 5) begin
            start = 1'b1;
            din   = 8'h00;
         end
         if (poke && n == 6) start = 1'b0;
         @(negedge clk);
      end
      check("start_bit_drive", 32'(ps2_d_oe), 32'd1);
   endtask

   task automatic run_xfer(input vec_t v);
      int   base;
      int   n;
      int   w;
      exp_t e;
      base        = done_cnt;
      e.frame     = {1'b1, v.par, v.din, 1'b0};
      e.ack_err   = v.exp_ack_err;
      e.tmo       = 1'b0;
      e.chk_frame = 1'b1;
      sb.push_back(e);
      begin_xfer(v.din, v.poke, n);
      check("c_oe_width", 32'(n), 32'(INH + 1));
      dev_clock(11, v.ack_low, v.poke);
      check("no_drive_in_ack", {30'd0, ps2_c_oe, ps2_d_oe}, 32'd0);
      repeat (H / 2) @(negedge clk);
      dev_d_low = 1'b0;
      w = 0;
      while (done_cnt == base && w < 200) begin
         @(negedge clk);
         w++;
      end
      repeat (50) @(negedge clk);
      check("single_done", 32'(done_cnt - base), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_bound act=expired exp=finished");
      $fatal(1);
   end

   initial begin
      int   base;
      int   n;
      int   w;
      int   t4;
      exp_t e;

      vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'hF4, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0};

      reset = 1'b0;
      start = 1'b0;
      din   = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_c_oe", 32'(ps2_c_oe), 32'd0);
      check("rst_d_oe", 32'(ps2_d_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ack_err", 32'(ack_err), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

      // Reset in the middle of SEND: lines and busy drop asynchronously, no done.
      base        = done_cnt;
      e.frame     = '0;
      e.ack_err   = 1'b0;
      e.tmo       = 1'b0;
      e.chk_frame = 1'b0;
      sb.push_back(e);
      begin_xfer(8'h00, 1'b0, n);
      dev_clock(3, 1'b0, 1'b0);
      check("d_oe_before_reset", 32'(ps2_d_oe), 32'd1);
      #3 reset = 1'b0;
      #1;
      check("midrst_c_oe", 32'(ps2_c_oe), 32'd0);
      check("midrst_d_oe", 32'(ps2_d_oe), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      void'(sb.pop_back());
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_idle_c_oe", 32'(ps2_c_oe), 32'd0);
      check("post_rst_no_done", 32'(done_cnt - base), 32'd0);
      $display("xfer reset mid-send busy=%b", busy);

      run_xfer(vecs[0]);

`ifdef PS2_TX_TIMEOUT_EN
      base        = done_cnt;
      e.frame     = '0;
      e.ack_err   = 1'b0;
      e.tmo       = 1'b1;
      e.chk_frame = 1'b0;
      sb.push_back(e);
      begin_xfer(8'h3C, 1'b0, n);
      dev_clock(4, 1'b0, 1'b0);
      t4 = cyc - H;
      w  = 0;
      while (done_cnt == base && w < TO + 200) begin
         @(negedge clk);
         w++;
      end
      check("timeout_done", 32'(done_cnt - base), 32'd1);
      check("timeout_latency", 32'((done_cyc - t4 >= TO) && (done_cyc - t4 <= TO + 8)), 32'd1);
      check("timeout_lines", {30'd0, ps2_c_oe, ps2_d_oe}, 32'd0);
      run_xfer(vecs[1]);
`endif

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
